// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared constants and types for the branch resolve unit
// Purpose: branch opcode, func3 condition codes, 2-bit history counter type,
//          its reset value and the saturating counter update helper.
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_func3_e;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken.
  localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - array of 2-bit branch history counters
// Purpose: one asynchronous read port for prediction lookup and one write
//          port that steps the addressed counter toward taken/not-taken.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (all entries -> 01)
//   rd_idx / rd_ctr   lookup index and current counter value (combinational)
//   wr_en, wr_idx     update strobe and index
//   wr_taken          resolved direction applied to the counter at wr_idx
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t mem [ENTRIES];

  // The read port sees the stored value, so a same-index lookup in the
  // update cycle returns the pre-update counter.
  assign rd_ctr = mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= BHT_CTR_RESET;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= bht_ctr_next(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - conditional branch resolution with 2-bit BHT prediction
// Purpose: evaluates branch conditions, computes target and next PC, flags
//          mispredicts and illegal encodings one cycle after the request,
//          trains a 2-bit history table and keeps saturating statistics.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   lookup_pc / lookup_taken     fetch-stage prediction lookup (combinational)
//   in_valid, in_opcode, in_func3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken
//                                resolve request
//   flush                        kills the request presented this cycle
//   out_valid, out_taken, out_mispredict, out_illegal, out_target, out_redirect_pc
//                                registered resolution result
//   stat_branches, stat_mispredicts  saturating event counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   lookup_pc,
  output logic              lookup_taken,
  input  logic              in_valid,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_func3,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_pred_taken,
  input  logic              flush,
  output logic              out_valid,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic              out_illegal,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic             req_live;
  logic             is_branch;
  logic             is_illegal;
  logic             is_legal;
  logic             cond;
  logic             taken;
  logic             mispredict;
  logic             do_update;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  redirect_pc;
  bht_ctr_t         lookup_ctr;
  logic             unused_pc_bits;

  // Only the word-index slice of the PCs feeds the table.
  assign unused_pc_bits = ^{lookup_pc, in_pc};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_pc[IDX_W+1:2]),
    .rd_ctr   (lookup_ctr),
    .wr_en    (do_update),
    .wr_idx   (in_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign lookup_taken = !rst && lookup_ctr[1];

  // Full-width relational compares rather than subtract-and-flag.
  always_comb begin
    cond = 1'b0;
    case (in_func3)
      F3_BEQ:  cond = (in_rs1 == in_rs2);
      F3_BNE:  cond = (in_rs1 != in_rs2);
      F3_BLT:  cond = ($signed(in_rs1) <  $signed(in_rs2));
      F3_BGE:  cond = ($signed(in_rs1) >= $signed(in_rs2));
      F3_BLTU: cond = (in_rs1 <  in_rs2);
      F3_BGEU: cond = (in_rs1 >= in_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign req_live    = in_valid && !flush;
  assign is_branch   = in_valid && (in_opcode == OPC_BRANCH);
  assign is_illegal  = is_branch && (in_func3[2:1] == 2'b01);
  assign is_legal    = is_branch && !is_illegal;
  assign taken       = is_legal && cond;
  assign mispredict  = is_legal && (taken ^ in_pred_taken);
  assign target      = in_pc + in_imm;
  assign redirect_pc = taken ? target : in_pc + XLEN'(4);
  assign do_update   = is_legal && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_taken        <= 1'b0;
      out_mispredict   <= 1'b0;
      out_illegal      <= 1'b0;
      out_target       <= '0;
      out_redirect_pc  <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      out_valid      <= req_live;
      out_taken      <= req_live && taken;
      out_mispredict <= req_live && mispredict;
      out_illegal    <= req_live && is_illegal;
      // Non-branch requests report zero addresses.
      if (req_live && is_branch) begin
        out_target      <= target;
        out_redirect_pc <= redirect_pc;
      end else begin
        out_target      <= '0;
        out_redirect_pc <= '0;
      end
      if (do_update && !(&stat_branches)) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (do_update && mispredict && !(&stat_mispredicts)) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        in_pred_taken;
  logic        flush;
  logic        out_valid, out_taken, out_mispredict, out_illegal;
  logic [31:0] out_target, out_redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        taken;
    logic        mis;
    logic        ill;
    logic        chk_addr;
    logic [31:0] target;
    logic [31:0] redirect;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t exp_q[$];

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .lookup_taken     (lookup_taken),
    .in_valid         (in_valid),
    .in_opcode        (in_opcode),
    .in_func3         (in_func3),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .in_pc            (in_pc),
    .in_imm           (in_imm),
    .in_pred_taken    (in_pred_taken),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_taken        (out_taken),
    .out_mispredict   (out_mispredict),
    .out_illegal      (out_illegal),
    .out_target       (out_target),
    .out_redirect_pc  (out_redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_opcode = '0; in_func3 = '0; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; in_pred_taken = 1'b0; flush = 1'b0;
  endtask

  // Drive one request at a negedge; the expectation is queued unless flushed.
  // lookup_pc follows in_pc so the same-index lookup shows the pre-update counter.
  task automatic send(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] pc, input logic [31:0] imm,
                      input logic pred, input logic fl,
                      input logic e_tk, input logic e_mis, input logic e_ill,
                      input logic e_chk, input logic [31:0] e_tgt, input logic [31:0] e_rd,
                      input logic [31:0] e_sb, input logic [31:0] e_sm,
                      input logic lk_chk, input logic lk_exp);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = opc; in_func3 = f3; in_rs1 = rs1; in_rs2 = rs2;
    in_pc = pc; in_imm = imm; in_pred_taken = pred; flush = fl; lookup_pc = pc;
    if (!fl) begin
      e.name = nm; e.taken = e_tk; e.mis = e_mis; e.ill = e_ill; e.chk_addr = e_chk;
      e.target = e_tgt; e.redirect = e_rd; e.sb = e_sb; e.sm = e_sm;
      exp_q.push_back(e);
    end
    #1;
    if (lk_chk) check({nm, ".lookup"}, {31'd0, lookup_taken}, {31'd0, lk_exp});
  endtask

  // Monitor: pops one expectation per presented result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no result");
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".taken"}, {31'd0, out_taken}, {31'd0, e.taken});
          check({e.name, ".mispredict"}, {31'd0, out_mispredict}, {31'd0, e.mis});
          check({e.name, ".illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
          if (e.chk_addr) begin
            check({e.name, ".target"}, out_target, e.target);
            check({e.name, ".redirect"}, out_redirect_pc, e.redirect);
          end
          check({e.name, ".stat_branches"}, stat_branches, e.sb);
          check({e.name, ".stat_mispredicts"}, stat_mispredicts, e.sm);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] BR = 7'b1100011;

  initial begin
    rst = 1'b1;
    lookup_pc = 32'h100;
    in_valid = 1'b0; in_opcode = '0; in_func3 = '0; in_rs1 = '0; in_rs2 = '0;
    in_pc = '0; in_imm = '0; in_pred_taken = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.lookup_taken", {31'd0, lookup_taken}, 32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.stat_branches", stat_branches, 32'd0);
    check("rst.stat_mispredicts", stat_mispredicts, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst.lookup_0x100", {31'd0, lookup_taken}, 32'd0);
    check("post_rst.stat_branches", stat_branches, 32'd0);

    //   name      opc f3     rs1           rs2           pc            imm           pr fl  tk ms il ca tgt           redirect      sb  sm  lc le
    send("blt",    BR, 3'b100, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       0, 0,  1, 1, 0, 1, 32'h240,      32'h240,      1,  1,  0, 0);
    send("bltu",   BR, 3'b110, 32'hFFFFFFFF, 32'h1,        32'h200,      32'h40,       0, 0,  0, 0, 0, 1, 32'h240,      32'h204,      2,  1,  0, 0);
    send("beq_t1", BR, 3'b000, 32'h5,        32'h5,        32'h300,      32'h8,        1, 0,  1, 0, 0, 1, 32'h308,      32'h308,      3,  1,  1, 0);
    send("beq_t2", BR, 3'b000, 32'h5,        32'h5,        32'h300,      32'h8,        1, 0,  1, 0, 0, 1, 32'h308,      32'h308,      4,  1,  1, 1);
    send("beq_t3", BR, 3'b000, 32'h5,        32'h5,        32'h300,      32'h8,        1, 0,  1, 0, 0, 1, 32'h308,      32'h308,      5,  1,  1, 1);
    send("beq_t4", BR, 3'b000, 32'h5,        32'h5,        32'h300,      32'h8,        1, 0,  1, 0, 0, 1, 32'h308,      32'h308,      6,  1,  1, 1);
    send("beq_n1", BR, 3'b000, 32'h5,        32'h6,        32'h300,      32'h8,        1, 0,  0, 1, 0, 1, 32'h308,      32'h304,      7,  2,  1, 1);
    send("beq_n2", BR, 3'b000, 32'h5,        32'h6,        32'h300,      32'h8,        0, 0,  0, 0, 0, 1, 32'h308,      32'h304,      8,  2,  1, 1);
    send("illegal",BR, 3'b010, 32'h7,        32'h7,        32'h404,      32'h10,       1, 0,  0, 0, 1, 0, 32'h0,        32'h0,        8,  2,  0, 0);
    send("flush",  BR, 3'b000, 32'h5,        32'h5,        32'h300,      32'h8,        0, 1,  0, 0, 0, 0, 32'h0,        32'h0,        0,  0,  1, 0);
    send("nonbr",  7'h33, 3'b000, 32'h5,     32'h5,        32'h300,      32'h8,        1, 0,  0, 0, 0, 0, 32'h0,        32'h0,        8,  2,  1, 0);
    send("wrap_t", BR, 3'b000, 32'h3,        32'h3,        32'hFFFFFFF0, 32'h20,       1, 0,  1, 0, 0, 1, 32'h10,       32'h10,       9,  2,  0, 0);
    send("wrap_n", BR, 3'b001, 32'h3,        32'h3,        32'hFFFFFFFC, 32'h8,        0, 0,  0, 0, 0, 1, 32'h4,        32'h0,        10, 2,  0, 0);
    send("bge",    BR, 3'b101, 32'h1,        32'hFFFFFFFF, 32'h500,      32'h100,      0, 0,  1, 1, 0, 1, 32'h600,      32'h600,      11, 3,  0, 0);
    send("bgeu",   BR, 3'b111, 32'h1,        32'hFFFFFFFF, 32'h500,      32'h100,      1, 0,  0, 1, 0, 1, 32'h600,      32'h504,      12, 4,  0, 0);
    send("bne",    BR, 3'b001, 32'h1,        32'h2,        32'h600,      32'hFFFFFFF0, 1, 0,  1, 0, 0, 1, 32'h5F0,      32'h5F0,      13, 4,  0, 0);
    idle();
    idle();
    idle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    // Asynchronous reset lands between edges while a result is held.
    send("async", BR, 3'b000, 32'h5, 32'h5, 32'h300, 32'h8, 0, 1,
         0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    flush = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst.out_taken", {31'd0, out_taken}, 32'd0);
    check("async_rst.out_target", out_target, 32'd0);
    check("async_rst.stat_branches", stat_branches, 32'd0);
    check("async_rst.stat_mispredicts", stat_mispredicts, 32'd0);
    check("async_rst.lookup_taken", {31'd0, lookup_taken}, 32'd0);
    idle();
    rst = 1'b0;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: operand, PC and immediate width.
REQ-002 Parameter BHT_ENTRIES, default 64: number of 2-bit history counters; must be a power of two and at least 2.
REQ-003 Parameter STAT_W, default 32: width of each statistics counter.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port lookup_pc, input, XLEN: fetch-stage PC for the prediction lookup.
REQ-007 Port lookup_taken, output, 1: combinational prediction, equal to bit 1 of the indexed counter.
REQ-008 Port in_valid, input, 1: a resolve request is present this cycle.
REQ-009 Ports in_opcode (7), in_func3 (3), in_rs1 (XLEN), in_rs2 (XLEN), in_pc (XLEN), in_imm (XLEN), in_pred_taken (1), all inputs: the instruction fields, operands and fetch-time prediction.
REQ-010 Port flush, input, 1: kills the request being registered this cycle.
REQ-011 Port out_valid, output, 1: registered result valid.
REQ-012 Ports out_taken (1), out_mispredict (1), out_illegal (1), all outputs: registered resolution flags.
REQ-013 Ports out_target (XLEN) and out_redirect_pc (XLEN), both outputs: registered branch target and correct next PC.
REQ-014 Ports stat_branches (STAT_W) and stat_mispredicts (STAT_W), both outputs: registered event counters.

Function
REQ-015 The BHT index SHALL be pc[IDX_W+1:2], where IDX_W = log2(BHT_ENTRIES); this applies to both lookup and update.
REQ-016 A request SHALL be a branch when in_valid=1 and in_opcode=7'b1100011; all other requests SHALL produce out_valid=1 with every flag low and no state change.
REQ-017 Conditions: func3 000 beq (rs1==rs2); 001 bne; 100 blt signed; 101 bge signed; 110 bltu unsigned; 111 bgeu unsigned.
REQ-018 Comparisons SHALL be full-width true compares, not derived from a subtraction sign or zero flag.
REQ-019 func3 010 or 011 on a branch opcode SHALL set out_illegal=1 and out_taken=0, and SHALL update neither the BHT nor any counter.
REQ-020 out_target SHALL equal in_pc+in_imm, modulo 2^XLEN.
REQ-021 out_redirect_pc SHALL equal out_target when taken, else in_pc+4, modulo 2^XLEN.
REQ-022 out_mispredict SHALL equal (taken XOR in_pred_taken) for legal branches and 0 otherwise.
REQ-023 Latency SHALL be exactly 1 cycle: the request sampled at edge N drives the outputs after edge N; outputs hold until the next edge.
REQ-024 When in_valid=0 or flush=1, the next out_valid SHALL be 0 and the other outputs SHALL be 0.
REQ-025 flush=1 SHALL also suppress the BHT update and counter increments for that request.
REQ-026 BHT update on a legal branch: a taken branch increments the counter saturating at 2'b11; a not-taken branch decrements it saturating at 2'b00.
REQ-027 The BHT write SHALL occur at the same edge the result is registered.
REQ-028 When lookup and update target the same index in the same cycle, lookup_taken SHALL return the pre-update value (read-before-write).
REQ-029 stat_branches SHALL increment once per legal, unflushed branch.
REQ-030 stat_mispredicts SHALL increment once per such branch with a mispredict.
REQ-031 Both statistics counters SHALL saturate at all-ones and never wrap.

Reset
REQ-032 While rst=1, every BHT counter SHALL be 2'b01 (weakly not-taken).
REQ-033 While rst=1, all out_* outputs and both statistics counters SHALL be 0.
REQ-034 While rst=1, lookup_taken SHALL be 0.
REQ-035 rst asserted mid-operation SHALL discard the in-flight result immediately, without waiting for a clock edge.

Structure
REQ-036 A shared package SHALL hold OPC_BRANCH, an enum of func3 branch codes, and the 2-bit counter type with its reset constant.
REQ-037 The BHT array SHALL be a sub-module bht_2bit: one asynchronous read port, one write port, and all-entry reset to 2'b01.

Verification
REQ-038 Reset, then lookup_pc=0x100 -> lookup_taken=0; both statistics counters read 0.
REQ-039 blt with rs1=0xFFFFFFFF, rs2=1, pc=0x200, imm=0x40, pred=0 -> next cycle out_taken=1, out_target=0x240, out_mispredict=1, stat_mispredicts=1.
REQ-040 bltu with rs1=0xFFFFFFFF, rs2=1, pc=0x200, pred=0 -> out_taken=0, out_redirect_pc=0x204, out_mispredict=0.
REQ-041 Same pc 0x300, taken beq three times, with lookup at 0x300 each cycle -> lookup_taken reads 0, 1, 1 (counter 01->10->11); a fourth taken branch holds the counter at 11.
REQ-042 func3=010 on a branch opcode -> out_illegal=1, out_taken=0, stat_branches unchanged; a branch with flush=1 -> out_valid=0 and no BHT change.
REQ-043 pc=0xFFFFFFF0, imm=0x20 -> out_target=0x10; pc=0xFFFFFFFC not-taken -> out_redirect_pc=0x0.
